// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline types: datapath widths, ALU control encodings and the
// ID/EX pipeline register layout.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADD2  = 2'b11
    } aluop_e;

    localparam logic [3:0] FUNCT_ADD  = 4'h0;
    localparam logic [3:0] FUNCT_SUB  = 4'h8;
    localparam logic [3:0] FUNCT_SLL  = 4'h1;
    localparam logic [3:0] FUNCT_SLT  = 4'h2;
    localparam logic [3:0] FUNCT_SLTU = 4'h3;
    localparam logic [3:0] FUNCT_XOR  = 4'h4;
    localparam logic [3:0] FUNCT_SRL  = 4'h5;
    localparam logic [3:0] FUNCT_SRA  = 4'hD;
    localparam logic [3:0] FUNCT_OR   = 4'h6;
    localparam logic [3:0] FUNCT_AND  = 4'h7;

    typedef struct packed {
        logic            valid;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            alusrc;
        logic [1:0]      aluop;
        logic [3:0]      funct;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
    } id_ex_t;
endpackage

// File: rtl/forward_unit.sv
// Per-operand bypass mux: EX/MEM beats MEM/WB, x0 never forwards.
module forward_unit #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic [RIDX-1:0] rs,
    input  logic [XLEN-1:0] rs_val,
    input  logic [RIDX-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RIDX-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd
);
    logic hit_mem, hit_wb;

    assign hit_mem = mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
    assign hit_wb  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs);

    always_comb begin
        fwd = rs_val;
        if (hit_mem)     fwd = mem_result;
        else if (hit_wb) fwd = wb_result;
    end
endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall/bubble.
module ex_operand_stage #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int RIDX = cpu_pkg::RIDX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RIDX-1:0] id_rs1,
    input  logic [RIDX-1:0] id_rs2,
    input  logic [RIDX-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alusrc,
    input  logic [1:0]      id_aluop,
    input  logic [3:0]      id_funct,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            flush,
    input  logic [RIDX-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RIDX-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [1:0]      ex_aluop,
    output logic [3:0]      ex_funct,
    output logic [RIDX-1:0] ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite
);
    import cpu_pkg::*;

    localparam int NUM_OPS = 2;

    id_ex_t q, d;
    logic   hz;

    logic [NUM_OPS-1:0][RIDX-1:0] op_idx;
    logic [NUM_OPS-1:0][XLEN-1:0] op_val;
    logic [NUM_OPS-1:0][XLEN-1:0] op_fwd;

    // Conservative: rs2 is compared even when the immediate replaces it.
    assign hz = q.valid && q.memread && (q.rd != '0) && id_valid &&
                ((q.rd == id_rs1) || (q.rd == id_rs2));
    assign stall = hz && !flush;

    always_comb begin
        d          = '0;
        d.valid    = id_valid;
        d.rs1      = id_rs1;
        d.rs2      = id_rs2;
        d.rd       = id_rd;
        d.rs1_val  = id_rs1_val;
        d.rs2_val  = id_rs2_val;
        d.imm      = id_imm;
        d.alusrc   = id_alusrc;
        d.aluop    = id_aluop;
        d.funct    = id_funct;
        d.regwrite = id_regwrite;
        d.memread  = id_memread;
        d.memwrite = id_memwrite;
    end

    // Bubble is the all-zero record, so flush and hazard share one path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          q <= '0;
        else if (flush || hz) q <= '0;
        else                 q <= d;
    end

    assign op_idx = {q.rs2, q.rs1};
    assign op_val = {q.rs2_val, q.rs1_val};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        forward_unit #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd (
            .rs          (op_idx[i]),
            .rs_val      (op_val[i]),
            .mem_rd      (mem_rd),
            .mem_regwrite(mem_regwrite),
            .mem_result  (mem_result),
            .wb_rd       (wb_rd),
            .wb_regwrite (wb_regwrite),
            .wb_result   (wb_result),
            .fwd         (op_fwd[i])
        );
    end

    assign ex_valid      = q.valid;
    assign ex_a          = op_fwd[0];
    assign ex_b          = q.alusrc ? q.imm : op_fwd[1];
    assign ex_store_data = op_fwd[1];
    assign ex_aluop      = q.aluop;
    assign ex_funct      = q.funct;
    assign ex_rd         = q.rd;
    assign ex_regwrite   = q.valid && q.regwrite;
    assign ex_memread    = q.valid && q.memread;
    assign ex_memwrite   = q.valid && q.memwrite;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding priority, x0 guard,
// load-use stall, flush override, immediate select and async reset.
module tb_ex_operand_stage;
    logic        clk, rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic        id_alusrc;
    logic [1:0]  id_aluop;
    logic [3:0]  id_funct;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_result, wb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [1:0]  ex_aluop;
    logic [3:0]  ex_funct;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite;

    int n_tests = 0;
    int n_fail  = 0;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .flush(flush),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] imm, input logic src, input logic [1:0] op,
                           input logic [3:0] fn, input logic rw, input logic mr, input logic mw);
        id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_val = v1; id_rs2_val = v2; id_imm = imm; id_alusrc = src;
        id_aluop = op; id_funct = fn; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        load_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_rd = 0; mem_regwrite = 0; mem_result = 0;
        wb_rd = 0; wb_regwrite = 0; wb_result = 0;
        #2;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_a", ex_a, 32'd0);
        chk("rst_b", ex_b, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
        step();
        rst_n = 1'b1;

        // ALU instruction rs1=5 rs2=6, then forward from MEM and WB
        load_id(1, 5, 6, 3, 32'h11, 32'h22, 0, 0, 2'b10, 4'h3, 1, 0, 0);
        step();
        chk("alu_valid", {31'd0, ex_valid}, 32'd1);
        chk("alu_rd", {27'd0, ex_rd}, 32'd3);
        chk("alu_aluop", {30'd0, ex_aluop}, 32'd2);
        chk("alu_funct", {28'd0, ex_funct}, 32'd3);
        chk("alu_regwrite", {31'd0, ex_regwrite}, 32'd1);
        chk("alu_a_nofwd", ex_a, 32'h11);
        chk("alu_b_nofwd", ex_b, 32'h22);
        mem_rd = 5; mem_regwrite = 1; mem_result = 32'hAAAA;
        wb_rd = 5; wb_regwrite = 1; wb_result = 32'hBBBB;
        #1 chk("fwd_mem_prio", ex_a, 32'hAAAA);
        mem_regwrite = 0;
        #1 chk("fwd_wb", ex_a, 32'hBBBB);
        wb_rd = 6; wb_result = 32'hCCCC;
        #1 chk("fwd_wb_rs2_b", ex_b, 32'hCCCC);
        chk("fwd_wb_rs2_sd", ex_store_data, 32'hCCCC);
        chk("fwd_wb_rs1_off", ex_a, 32'h11);
        wb_regwrite = 0;

        // x0 never forwards
        load_id(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        mem_rd = 0; mem_regwrite = 1; mem_result = 32'h1234;
        wb_rd = 0; wb_regwrite = 1; wb_result = 32'h5678;
        #1 chk("x0_guard", ex_a, 32'h0);
        mem_regwrite = 0; wb_regwrite = 0;

        // load to x0 followed by reader of x0: no stall
        load_id(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        load_id(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("hz_x0_nostall", {31'd0, stall}, 32'd0);

        // load-use through rs2
        load_id(1, 1, 2, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        load_id(1, 3, 7, 9, 32'h33, 32'h77, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("hz_stall", {31'd0, stall}, 32'd1);
        step();
        chk("hz_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("hz_bubble_memread", {31'd0, ex_memread}, 32'd0);
        chk("hz_bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("hz_stall_clear", {31'd0, stall}, 32'd0);
        step();
        chk("hz_resume_valid", {31'd0, ex_valid}, 32'd1);
        chk("hz_resume_rd", {27'd0, ex_rd}, 32'd9);
        chk("hz_resume_a", ex_a, 32'h33);

        // flush overrides a pending hazard
        load_id(1, 1, 2, 7, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step();
        load_id(1, 3, 7, 9, 32'h33, 32'h77, 0, 0, 0, 0, 1, 0, 1);
        flush = 1'b1;
        #1 chk("flush_stall", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("flush_memread", {31'd0, ex_memread}, 32'd0);
        chk("flush_memwrite", {31'd0, ex_memwrite}, 32'd0);

        // immediate select on b, store data keeps rs2
        load_id(1, 8, 4, 10, 32'h55, 32'd9, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 1);
        step();
        chk("imm_b", ex_b, 32'hFFFF_FFFC);
        chk("imm_store_data", ex_store_data, 32'd9);
        chk("imm_memwrite", {31'd0, ex_memwrite}, 32'd1);
        chk("imm_a", ex_a, 32'h55);

        // async reset mid-stream, then synchronous recovery
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mrst_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("mrst_a", ex_a, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        #1 chk("mrst_hold", {31'd0, ex_valid}, 32'd0);
        step();
        chk("mrst_recover", {31'd0, ex_valid}, 32'd1);
        chk("mrst_recover_a", ex_a, 32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
